// File: rtl/yc_noc_rr_arb.sv
// Round-robin, packet-locking N:1 arbiter for a NoC output channel.
// The granted beat is captured in a one-entry output register that refills while it drains.
module yc_noc_rr_arb #(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      s_valid,
  input  logic [N*W-1:0]    s_data,
  input  logic [N-1:0]      s_last,
  output logic [N-1:0]      s_ready,
  output logic              m_valid,
  output logic [W-1:0]      m_data,
  output logic              m_last,
  output logic [IW-1:0]     m_src,
  input  logic              m_ready
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   lock_id_reg, lock_id_next;
  logic            out_full_reg, out_full_next;
  logic [W-1:0]    out_data_reg, out_data_next;
  logic            out_last_reg, out_last_next;
  logic [IW-1:0]   out_src_reg, out_src_next;

  logic [W-1:0]    s_data_arr [N];
  logic [IW-1:0]   rr_pick;
  logic [IW-1:0]   gnt;
  logic            any_valid;
  logic            can_acc;
  logic            xfer;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign s_data_arr[gi] = s_data[gi*W +: W];
    end
  endgenerate

  // Modular add that wraps at N, so non-power-of-2 N never reaches an unused index.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  // Scan from the highest offset down so the candidate nearest ptr wins.
  always_comb begin
    rr_pick   = ptr_reg;
    any_valid = |s_valid;
    for (int k = N - 1; k >= 0; k--) begin
      if (s_valid[rr_idx(ptr_reg, k)]) rr_pick = rr_idx(ptr_reg, k);
    end
  end

  assign gnt     = (state_reg == LOCK) ? lock_id_reg : rr_pick;
  assign can_acc = !out_full_reg || m_ready;

  always_comb begin
    s_ready = '0;
    if (!rst && can_acc && (state_reg == LOCK || any_valid)) s_ready[gnt] = 1'b1;
  end

  assign xfer = s_valid[gnt] && s_ready[gnt];

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lock_id_next  = lock_id_reg;
    out_full_next = out_full_reg;
    out_data_next = out_data_reg;
    out_last_next = out_last_reg;
    out_src_next  = out_src_reg;
    if (xfer) begin
      out_full_next = 1'b1;
      out_data_next = s_data_arr[gnt];
      out_last_next = s_last[gnt];
      out_src_next  = gnt;
      if (s_last[gnt]) begin
        state_next = IDLE;
        ptr_next   = rr_idx(gnt, 1);
      end else begin
        state_next   = LOCK;
        lock_id_next = gnt;
      end
    end else if (m_ready && out_full_reg) begin
      out_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      lock_id_reg  <= '0;
      out_full_reg <= 1'b0;
      out_data_reg <= '0;
      out_last_reg <= 1'b0;
      out_src_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lock_id_reg  <= lock_id_next;
      out_full_reg <= out_full_next;
      out_data_reg <= out_data_next;
      out_last_reg <= out_last_next;
      out_src_reg  <= out_src_next;
    end
  end

  assign m_valid = out_full_reg;
  assign m_data  = out_data_reg;
  assign m_last  = out_last_reg;
  assign m_src   = out_src_reg;

endmodule

// File: tb/tb_yc_noc_rr_arb.sv
// Directed bench for yc_noc_rr_arb: a 4-requester instance for most scenarios
// and a 3-requester instance for the non-power-of-2 pointer wrap.
module tb_yc_noc_rr_arb;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]     s_valid, s_last, s_ready;
  logic [4*W-1:0] s_data;
  logic [W-1:0]   d4 [4];
  logic           m_valid, m_last, m_ready;
  logic [W-1:0]   m_data;
  logic [1:0]     m_src;

  logic [2:0]     s_valid3, s_last3, s_ready3;
  logic [3*W-1:0] s_data3;
  logic [W-1:0]   d3 [3];
  logic           m_valid3, m_last3, m_ready3;
  logic [W-1:0]   m_data3;
  logic [1:0]     m_src3;

  assign s_data  = {d4[3], d4[2], d4[1], d4[0]};
  assign s_data3 = {d3[2], d3[1], d3[0]};

  int tests_run = 0;
  int tests_failed = 0;

  yc_noc_rr_arb #(.N(4), .W(W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .m_ready(m_ready)
  );

  yc_noc_rr_arb #(.N(3), .W(W)) dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid3), .s_data(s_data3), .s_last(s_last3),
    .s_ready(s_ready3), .m_valid(m_valid3), .m_data(m_data3), .m_last(m_last3),
    .m_src(m_src3), .m_ready(m_ready3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] i, input logic v, input logic [W-1:0] d, input logic l);
    s_valid[i] = v;
    d4[i]      = d;
    s_last[i]  = l;
  endtask

  task automatic drv3(input logic [1:0] i, input logic v, input logic [W-1:0] d, input logic l);
    s_valid3[i] = v;
    d3[i]       = d;
    s_last3[i]  = l;
  endtask

  // Payload for requester k, beat j.
  function automatic logic [W-1:0] bd(input int k, input int j);
    return 8'(16 * (k + 1) + j);
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1;
    m_ready = 1'b1;
    m_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) drv(2'(i), 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 3; i++) drv3(2'(i), 1'b1, 8'hEE, 1'b0);
    cyc();
    cyc();
    got = {m_valid, m_last, m_src, m_data};
    tests_run++;
    if (got !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want %h", got, 12'h000);
    end
    tests_run++;
    if (s_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_s_ready: got %b want %b", s_ready, 4'b0000);
    end
    tests_run++;
    if (s_ready3 !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_s_ready_n3: got %b want %b", s_ready3, 3'b000);
    end
    s_valid = '0;
    s_valid3 = '0;
    rst = 1'b0;
    cyc();
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    logic [11:0] exp_beat;
    for (int j = 0; j < 3; j++) begin
      drv(2'd2, 1'b1, bd(2, j), 1'(j == 2));
      #1;
      tests_run++;
      if (s_ready !== 4'b0100) begin
        tests_failed++;
        $display("FAIL single_ready beat %0d: got %b want %b", j, s_ready, 4'b0100);
      end
      cyc();
      exp_beat = {1'b1, 1'(j == 2), 2'd2, bd(2, j)};
      tests_run++;
      if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
        tests_failed++;
        $display("FAIL single_beat %0d: got %h want %h", j, {m_valid, m_last, m_src, m_data}, exp_beat);
      end
    end
    // ptr must now be 3: req 3 beats req 0.
    drv(2'd2, 1'b0, 8'h00, 1'b0);
    drv(2'd0, 1'b1, bd(0, 9), 1'b1);
    drv(2'd3, 1'b1, bd(3, 0), 1'b1);
    #1;
    tests_run++;
    if (s_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL single_ptr3: got %b want %b", s_ready, 4'b1000);
    end
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd3, bd(3, 0)};
    tests_run++;
    if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
      tests_failed++;
      $display("FAIL single_ptr3_beat: got %h want %h", {m_valid, m_last, m_src, m_data}, exp_beat);
    end
    s_valid = '0;
    cyc();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: got %b want 0", m_valid);
    end
    $display("[TB] single requester 3-beat packet checked");
  endtask

  task automatic test_contention();
    int a, b, src;
    logic [11:0] exp_beat;
    logic [3:0] exp_rdy;
    for (int p = 0; p < 2; p++) begin
      a = p;
      b = 1 - p;
      if (p == 1) begin
        // One single-beat packet from req 0 moves ptr from 2 to 1.
        drv(2'd0, 1'b1, 8'h55, 1'b1);
        #1;
        tests_run++;
        if (s_ready !== 4'b0001) begin
          tests_failed++;
          $display("FAIL contention_setup: got %b want %b", s_ready, 4'b0001);
        end
        cyc();
        drv(2'd0, 1'b0, 8'h00, 1'b0);
      end
      for (int c = 0; c < 5; c++) begin
        if (c > 0) begin
          src = (c - 1 < 2) ? a : b;
          exp_beat = {1'b1, 1'((c - 1) % 2 == 1), 2'(src), bd(src, (c - 1) % 2)};
          tests_run++;
          if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
            tests_failed++;
            $display("FAIL contention_beat ptr=%0d c=%0d: got %h want %h", p, c,
                     {m_valid, m_last, m_src, m_data}, exp_beat);
          end
        end
        if (c < 2) drv(2'(a), 1'b1, bd(a, c), 1'(c == 1));
        else       drv(2'(a), 1'b0, 8'h00, 1'b0);
        if (c < 3)       drv(2'(b), 1'b1, bd(b, 0), 1'b0);
        else if (c == 3) drv(2'(b), 1'b1, bd(b, 1), 1'b1);
        else             drv(2'(b), 1'b0, 8'h00, 1'b0);
        #1;
        exp_rdy = (c < 2) ? 4'(1 << a) : (c < 4) ? 4'(1 << b) : 4'b0000;
        tests_run++;
        if (s_ready !== exp_rdy) begin
          tests_failed++;
          $display("FAIL contention_ready ptr=%0d c=%0d: got %b want %b", p, c, s_ready, exp_rdy);
        end
        cyc();
      end
      tests_run++;
      if (m_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL contention_drain ptr=%0d: got %b want 0", p, m_valid);
      end
      $display("[TB] contention with ptr=%0d checked", p);
    end
  endtask

  task automatic test_lock_hold();
    logic [11:0] exp_beat;
    drv(2'd0, 1'b1, bd(0, 0), 1'b0);
    #1;
    tests_run++;
    if (s_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL lock_first_ready: got %b want %b", s_ready, 4'b0001);
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      drv(2'd0, 1'b0, bd(0, 1), 1'b0);
      drv(2'd3, 1'b1, bd(3, 0), 1'b1);
      #1;
      tests_run++;
      if (s_ready !== 4'b0001) begin
        tests_failed++;
        $display("FAIL lock_hold_ready k=%0d: got %b want %b", k, s_ready, 4'b0001);
      end
      cyc();
      tests_run++;
      if (m_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL lock_hold_no_beat k=%0d: got %b want 0", k, m_valid);
      end
    end
    drv(2'd0, 1'b1, bd(0, 1), 1'b1);
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd0, bd(0, 1)};
    tests_run++;
    if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
      tests_failed++;
      $display("FAIL lock_last_beat: got %h want %h", {m_valid, m_last, m_src, m_data}, exp_beat);
    end
    drv(2'd0, 1'b0, 8'h00, 1'b0);
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd3, bd(3, 0)};
    tests_run++;
    if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
      tests_failed++;
      $display("FAIL lock_release_req3: got %h want %h", {m_valid, m_last, m_src, m_data}, exp_beat);
    end
    drv(2'd3, 1'b0, 8'h00, 1'b0);
    cyc();
    $display("[TB] lock hold checked");
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_beat;
    drv(2'd1, 1'b1, bd(1, 0), 1'b0);
    cyc();
    m_ready = 1'b0;
    drv(2'd1, 1'b1, bd(1, 1), 1'b1);
    exp_beat = {1'b1, 1'b0, 2'd1, bd(1, 0)};
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if (s_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_ready k=%0d: got %b want %b", k, s_ready, 4'b0000);
      end
      tests_run++;
      if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
        tests_failed++;
        $display("FAIL bp_hold k=%0d: got %h want %h", k, {m_valid, m_last, m_src, m_data}, exp_beat);
      end
      cyc();
    end
    m_ready = 1'b1;
    #1;
    tests_run++;
    if (s_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_resume_ready: got %b want %b", s_ready, 4'b0010);
    end
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd1, bd(1, 1)};
    tests_run++;
    if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
      tests_failed++;
      $display("FAIL bp_resume_beat: got %h want %h", {m_valid, m_last, m_src, m_data}, exp_beat);
    end
    drv(2'd1, 1'b0, 8'h00, 1'b0);
    cyc();
    $display("[TB] backpressure checked");
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp_beat;
    drv(2'd1, 1'b1, bd(1, 0), 1'b0);
    cyc();
    drv(2'd1, 1'b1, bd(1, 1), 1'b0);
    cyc();
    drv(2'd1, 1'b1, bd(1, 2), 1'b0);
    drv(2'd0, 1'b1, bd(0, 0), 1'b1);
    #1;
    tests_run++;
    if (s_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rstmid_locked: got %b want %b", s_ready, 4'b0010);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({m_valid, m_last, m_src, m_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got %h want %h", {m_valid, m_last, m_src, m_data}, 12'h000);
    end
    tests_run++;
    if (s_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rstmid_ready: got %b want %b", s_ready, 4'b0000);
    end
    cyc();
    rst = 1'b0;
    #1;
    tests_run++;
    if (s_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rstmid_restart_ready: got %b want %b", s_ready, 4'b0001);
    end
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd0, bd(0, 0)};
    tests_run++;
    if ({m_valid, m_last, m_src, m_data} !== exp_beat) begin
      tests_failed++;
      $display("FAIL rstmid_restart_beat: got %h want %h", {m_valid, m_last, m_src, m_data}, exp_beat);
    end
    s_valid = '0;
    cyc();
    $display("[TB] reset mid-packet checked");
  endtask

  task automatic test_wrap3();
    logic [11:0] exp_beat;
    drv3(2'd1, 1'b1, bd(1, 0), 1'b1);
    cyc();
    drv3(2'd1, 1'b0, 8'h00, 1'b0);
    drv3(2'd0, 1'b1, bd(0, 0), 1'b1);
    drv3(2'd2, 1'b1, bd(2, 0), 1'b0);
    #1;
    tests_run++;
    if (s_ready3 !== 3'b100) begin
      tests_failed++;
      $display("FAIL wrap3_grant2: got %b want %b", s_ready3, 3'b100);
    end
    cyc();
    drv3(2'd2, 1'b1, bd(2, 1), 1'b1);
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd2, bd(2, 1)};
    tests_run++;
    if ({m_valid3, m_last3, m_src3, m_data3} !== exp_beat) begin
      tests_failed++;
      $display("FAIL wrap3_last_beat: got %h want %h", {m_valid3, m_last3, m_src3, m_data3}, exp_beat);
    end
    drv3(2'd2, 1'b1, bd(2, 2), 1'b1);
    #1;
    tests_run++;
    if (s_ready3 !== 3'b001) begin
      tests_failed++;
      $display("FAIL wrap3_ptr0: got %b want %b", s_ready3, 3'b001);
    end
    cyc();
    exp_beat = {1'b1, 1'b1, 2'd0, bd(0, 0)};
    tests_run++;
    if ({m_valid3, m_last3, m_src3, m_data3} !== exp_beat) begin
      tests_failed++;
      $display("FAIL wrap3_req0_beat: got %h want %h", {m_valid3, m_last3, m_src3, m_data3}, exp_beat);
    end
    s_valid3 = '0;
    cyc();
    $display("[TB] N=3 pointer wrap checked");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock_hold();
    test_backpressure();
    test_reset_mid();
    test_wrap3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
